bp_update_queue: RTL and testbench

//  Buffers committed conditional-branch outcomes from the ROB commit stage.

---
 rtl/bp_update_queue.sv | 109 ++++++++++
 tb/tb_bp_update_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - committed-branch queue feeding predictor training updates, one per cycle
// Optional mispredict counter enabled by defining BPQ_MISPRED_STATS_EN.
module bp_update_queue #(
  parameter int BPQ_DEPTH_WIDTH = 2,
  parameter int XLEN            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_pred,
  input  logic            commit_jump,
  output logic            bpq_full,
  output logic            rob_bp_enable,
  output logic [XLEN-1:0] rob_bp_inst_addr,
  output logic            rob_bp_jump,
  output logic            rob_bp_correct,
  output logic [XLEN-1:0] bpq_mispred_cnt
);

  localparam int DEPTH = 1 << BPQ_DEPTH_WIDTH;
  localparam logic [BPQ_DEPTH_WIDTH:0]   FULL_COUNT = {1'b1, {BPQ_DEPTH_WIDTH{1'b0}}};
  localparam logic [BPQ_DEPTH_WIDTH:0]   CNT_ONE    = (BPQ_DEPTH_WIDTH+1)'(1);
  localparam logic [BPQ_DEPTH_WIDTH-1:0] PTR_ONE    = BPQ_DEPTH_WIDTH'(1);

  logic [XLEN-1:0]            pc_mem      [DEPTH];
  logic                       jump_mem    [DEPTH];
  logic                       correct_mem [DEPTH];

  logic [BPQ_DEPTH_WIDTH-1:0] head;
  logic [BPQ_DEPTH_WIDTH-1:0] tail;
  logic [BPQ_DEPTH_WIDTH:0]   count;
  logic [BPQ_DEPTH_WIDTH:0]   count_nxt;
  logic                       push;
  logic                       pop;

  // Full is derived from registered count only, so the ROB sees a stable stall.
  assign bpq_full = (count == FULL_COUNT);
  assign push     = commit_valid && !bpq_full;
  // A flushed cycle means the predictor ignored the presented update; keep it.
  assign pop      = !flush && (count != '0);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rdy && !rst && push) begin
      pc_mem[tail]      <= commit_pc;
      jump_mem[tail]    <= commit_jump;
      correct_mem[tail] <= ~(commit_pred ^ commit_jump);
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        head             <= '0;
        tail             <= '0;
        count            <= '0;
        rob_bp_enable    <= 1'b0;
        rob_bp_inst_addr <= '0;
        rob_bp_jump      <= 1'b0;
        rob_bp_correct   <= 1'b0;
      end else begin
        count <= count_nxt;
        if (push) begin
          tail <= tail + PTR_ONE;
        end
        if (pop) begin
          head             <= head + PTR_ONE;
          rob_bp_enable    <= 1'b1;
          rob_bp_inst_addr <= pc_mem[head];
          rob_bp_jump      <= jump_mem[head];
          rob_bp_correct   <= correct_mem[head];
        end else if (!flush) begin
          rob_bp_enable <= 1'b0;
        end
      end
    end
  end

`ifdef BPQ_MISPRED_STATS_EN
  logic [XLEN-1:0] mispred_q;

  // Counted on the edge the predictor actually consumes the update.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        mispred_q <= '0;
      end else if (!flush && rob_bp_enable && !rob_bp_correct) begin
        mispred_q <= mispred_q + XLEN'(1);
      end
    end
  end

  assign bpq_mispred_cnt = mispred_q;
`else
  assign bpq_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - table-driven and sequence checks for bp_update_queue
module tb_bp_update_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b0, flush = 1'b0, commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic        commit_pred = 1'b0, commit_jump = 1'b0;
  logic        bpq_full, rob_bp_enable, rob_bp_jump, rob_bp_correct;
  logic [31:0] rob_bp_inst_addr, bpq_mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bp_update_queue #(.BPQ_DEPTH_WIDTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_pred(commit_pred), .commit_jump(commit_jump),
    .bpq_full(bpq_full), .rob_bp_enable(rob_bp_enable),
    .rob_bp_inst_addr(rob_bp_inst_addr), .rob_bp_jump(rob_bp_jump),
    .rob_bp_correct(rob_bp_correct), .bpq_mispred_cnt(bpq_mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, fl, cv;
    logic [31:0] pc;
    logic        pd, jp;
    logic        full, en;
    logic [31:0] addr;
    logic        ej, ec;
    logic [31:0] mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        j, c;
  } upd_t;

  vec_t vq[$];
  upd_t sb[$];

  task automatic add(input logic r, input logic rd, input logic fl, input logic cv,
                     input logic [31:0] pc, input logic pd, input logic jp,
                     input logic full, input logic en, input logic [31:0] addr,
                     input logic ej, input logic ec, input logic [31:0] mis);
    vec_t v;
    v.rst = r; v.rdy = rd; v.fl = fl; v.cv = cv; v.pc = pc; v.pd = pd; v.jp = jp;
    v.full = full; v.en = en; v.addr = addr; v.ej = ej; v.ec = ec; v.mis = mis;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mis_exp(input logic [31:0] m);
`ifdef BPQ_MISPRED_STATS_EN
    return m;
`else
    return 32'd0 & m;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, delivered, wrap_mis;
    upd_t u;

    //   rst rdy fl cv  pc      pd jp  full en addr     ej ec mis
    add(1, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   0, 0, 0);  // reset
    add(0, 1, 0, 1, 32'h100, 0, 1,  0, 0, 32'h0,   0, 0, 0);  // single commit
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h100, 1, 0, 0);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h100, 1, 0, 1);
    add(0, 1, 0, 1, 32'h10,  1, 1,  0, 0, 32'h100, 1, 0, 1);  // burst
    add(0, 1, 0, 1, 32'h14,  0, 0,  0, 1, 32'h10,  1, 1, 1);
    add(0, 1, 0, 1, 32'h18,  1, 0,  0, 1, 32'h14,  0, 1, 1);
    add(0, 1, 0, 1, 32'h1C,  0, 1,  0, 1, 32'h18,  0, 0, 1);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h1C,  1, 0, 2);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h1C,  1, 0, 3);
    add(0, 1, 1, 1, 32'h300, 1, 1,  0, 0, 32'h1C,  1, 0, 3);  // overflow guard
    add(0, 1, 1, 1, 32'h304, 1, 0,  0, 0, 32'h1C,  1, 0, 3);
    add(0, 1, 1, 1, 32'h308, 0, 0,  0, 0, 32'h1C,  1, 0, 3);
    add(0, 1, 1, 1, 32'h30C, 0, 1,  1, 0, 32'h1C,  1, 0, 3);
    add(0, 1, 1, 1, 32'h310, 1, 1,  1, 0, 32'h1C,  1, 0, 3);  // dropped while full
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h300, 1, 1, 3);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h304, 0, 0, 3);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h308, 0, 1, 4);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h30C, 1, 0, 4);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h30C, 1, 0, 5);
    add(0, 1, 0, 1, 32'h200, 1, 0,  0, 0, 32'h30C, 1, 0, 5);  // flush hold
    add(0, 1, 0, 1, 32'h204, 1, 1,  0, 1, 32'h200, 0, 0, 5);
    add(0, 1, 1, 0, 32'h0,   0, 0,  0, 1, 32'h200, 0, 0, 5);
    add(0, 1, 1, 0, 32'h0,   0, 0,  0, 1, 32'h200, 0, 0, 5);
    add(0, 1, 1, 0, 32'h0,   0, 0,  0, 1, 32'h200, 0, 0, 5);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 1, 32'h204, 1, 1, 6);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h204, 1, 1, 6);
    add(0, 0, 0, 1, 32'h400, 0, 0,  0, 0, 32'h204, 1, 1, 6);  // rdy low freezes
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h204, 1, 1, 6);
    add(0, 1, 1, 1, 32'h500, 0, 1,  0, 0, 32'h204, 1, 1, 6);  // reset mid-op
    add(0, 1, 1, 1, 32'h504, 1, 0,  0, 0, 32'h204, 1, 1, 6);
    add(0, 1, 1, 1, 32'h508, 1, 1,  0, 0, 32'h204, 1, 1, 6);
    add(1, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   0, 0, 0);
    add(0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 32'h0,   0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; rdy = vq[i].rdy; flush = vq[i].fl; commit_valid = vq[i].cv;
      commit_pc = vq[i].pc; commit_pred = vq[i].pd; commit_jump = vq[i].jp;
      @(posedge clk);
      #1;
      check($sformatf("row%0d full", i), {31'd0, bpq_full}, {31'd0, vq[i].full});
      check($sformatf("row%0d enable", i), {31'd0, rob_bp_enable}, {31'd0, vq[i].en});
      check($sformatf("row%0d addr", i), rob_bp_inst_addr, vq[i].addr);
      check($sformatf("row%0d jump", i), {31'd0, rob_bp_jump}, {31'd0, vq[i].ej});
      check($sformatf("row%0d correct", i), {31'd0, rob_bp_correct}, {31'd0, vq[i].ec});
      check($sformatf("row%0d mispred_cnt", i), bpq_mispred_cnt, mis_exp(vq[i].mis));
    end

    // Wrap-around: 10 commits with periodic flushes; scoreboard checks order on consumption.
    k = 0; delivered = 0; wrap_mis = 0;
    rst = 1'b0; rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && delivered < 10; cyc++) begin
      @(negedge clk);
      flush = (cyc % 4 == 2);
      if (!flush && rob_bp_enable) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wrap_spurious: got update %0h expected none", rob_bp_inst_addr);
        end else begin
          u = sb.pop_front();
          check($sformatf("wrap%0d addr", delivered), rob_bp_inst_addr, u.pc);
          check($sformatf("wrap%0d jump", delivered), {31'd0, rob_bp_jump}, {31'd0, u.j});
          check($sformatf("wrap%0d correct", delivered), {31'd0, rob_bp_correct}, {31'd0, u.c});
          if (!u.c) wrap_mis++;
        end
        delivered++;
      end
      commit_valid = (k < 10) && !bpq_full;
      if (commit_valid) begin
        commit_pc   = 32'h600 + 32'(4 * k);
        commit_pred = k[0];
        commit_jump = k[1];
        sb.push_back('{32'h600 + 32'(4 * k), k[1], (k[0] == k[1])});
        k++;
      end
      @(posedge clk);
    end
    #1;
    commit_valid = 1'b0;
    flush = 1'b0;
    check("wrap_pushed", k, 10);
    check("wrap_delivered", delivered, 10);
    check("wrap_mispred_cnt", bpq_mispred_cnt, mis_exp(wrap_mis));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
